// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
// Initiator side of the multiply/divide unit interface. MD operations from
// the E stage are queued in a small circular FIFO and issued to the MDU one
// at a time. HI/LO reads stall until all earlier MD operations have completed.
// An exception request flushes un-issued entries and is forwarded to the MDU.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req               exception request (flushes queue, forwarded as mdu_req)
//   in_valid/ready    E-stage push handshake; in_type/in_rs/in_rt payload
//   rd_valid/rd_type  E-stage MFHI/MFLO request; rd_stall holds it
//   mdu_start         one-cycle issue strobe with mdu_type/mdu_rs/mdu_rt
//   mdu_busy          MDU busy flag
//   mdu_req           combinational copy of req
module md_issue_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_type,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic        rd_valid,
    input  logic [3:0]  rd_type,
    output logic        rd_stall,
    output logic        mdu_start,
    output logic [3:0]  mdu_type,
    output logic [31:0] mdu_rs,
    output logic [31:0] mdu_rt,
    input  logic        mdu_busy,
    output logic        mdu_req
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;

    logic [3:0]    type_mem [DEPTH];
    logic [31:0]   rs_mem   [DEPTH];
    logic [31:0]   rt_mem   [DEPTH];

    logic          push;
    logic          pop;
    logic          not_empty;
    logic [3:0]    head_type;
    logic          head_long;   // MULT/MULTU/DIV/DIVU: occupies the MDU
    logic          head_legal;  // anything the MDU understands as a start

    assign not_empty  = (count_q != '0);
    assign head_type  = type_mem[head_q];
    assign head_long  = (head_type >= 4'd1) && (head_type <= 4'd4);
    assign head_legal = head_long || (head_type == 4'd7) || (head_type == 4'd8);

    // A full FIFO with a pending pop still reports not-ready; no bypass paths.
    assign in_ready = (count_q < FULL_COUNT) && !req;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_IDLE) && not_empty && !mdu_busy && !req;

    assign mdu_req  = req;
    assign mdu_rs   = not_empty ? rs_mem[head_q] : 32'd0;
    assign mdu_rt   = not_empty ? rt_mem[head_q] : 32'd0;
    assign rd_stall = rd_valid && (not_empty || (state_q == ST_BUSY) || mdu_busy || req);

    // Storage: one write-enabled register set per entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_q == gi[AW-1:0])) begin
                    type_mem[gi] <= in_type;
                    rs_mem[gi]   <= in_rs;
                    rt_mem[gi]   <= in_rt;
                end
            end
        end
    endgenerate

    // Illegal types are popped silently: pop without a start strobe.
    always_comb begin
        state_d   = state_q;
        mdu_start = 1'b0;
        mdu_type  = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (pop && head_legal) begin
                    mdu_start = 1'b1;
                    if (head_long) begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // The MDU raises busy on the issuing edge, so a 0 here is real.
                if (!mdu_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (mdu_start) begin
            mdu_type = head_type;
        end else if (rd_valid) begin
            mdu_type = rd_type;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (req) begin
            // Flush: the FSM state is kept since the MDU only freezes.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
